// File: rtl/ecc_pkg.sv
// Shared types for the ECC operation sequencer: operation codes, FSM states,
// APB register map and codeword-width masks.
package ecc_pkg;

  typedef enum logic [1:0] {
    OP_ENC  = 2'd0,
    OP_DEC  = 2'd1,
    OP_FULL = 2'd2
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENC_START,
    S_ENC_WAIT,
    S_DEC_START,
    S_DEC_WAIT,
    S_DONE
  } state_t;

  localparam logic [7:0] ADDR_CTRL  = 8'h00;
  localparam logic [7:0] ADDR_DATA  = 8'h04;
  localparam logic [7:0] ADDR_WIDTH = 8'h08;
  localparam logic [7:0] ADDR_NOISE = 8'h0C;

  localparam logic [1:0] WCODE_8    = 2'd0;
  localparam logic [1:0] WCODE_16   = 2'd1;
  localparam logic [1:0] WCODE_32   = 2'd2;
  localparam logic [1:0] CODE_ILLEG = 2'd3;

  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  function automatic logic [31:0] width_mask(input logic [1:0] code);
    case (code)
      WCODE_8:  return 32'h0000_00FF;
      WCODE_16: return 32'h0000_FFFF;
      default:  return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/ecc_apb_regs.sv
// APB register file for the ECC sequencer: decode, storage, error flag and
// the launch strobe raised by an accepted CTRL write.
module ecc_apb_regs
  import ecc_pkg::*;
#(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       psel_i,
  input  logic                       penable_i,
  input  logic                       pwrite_i,
  input  logic [AMBA_ADDR_WIDTH-1:0] paddr_i,
  input  logic [AMBA_WORD-1:0]       pwdata_i,
  output logic [AMBA_WORD-1:0]       prdata_o,
  output logic                       pslverr_o,
  input  logic                       busy_i,
  output logic                       launch_o,
  output op_t                        launch_op_o,
  output logic [AMBA_WORD-1:0]       data_in_o,
  output logic [1:0]                 width_o,
  output logic [AMBA_WORD-1:0]       noise_o
);

  logic [1:0]           ctrl_q;
  logic [AMBA_WORD-1:0] data_in_q;
  logic [1:0]           width_q;
  logic [AMBA_WORD-1:0] noise_q;

  logic wr, rd;
  logic sel_ctrl, sel_data, sel_width, sel_noise, mapped;
  logic bad_val, wr_err, wr_ok;

  assign wr = psel_i & penable_i & pwrite_i;
  assign rd = psel_i & penable_i & ~pwrite_i;

  assign sel_ctrl  = (paddr_i == AMBA_ADDR_WIDTH'(ADDR_CTRL));
  assign sel_data  = (paddr_i == AMBA_ADDR_WIDTH'(ADDR_DATA));
  assign sel_width = (paddr_i == AMBA_ADDR_WIDTH'(ADDR_WIDTH));
  assign sel_noise = (paddr_i == AMBA_ADDR_WIDTH'(ADDR_NOISE));
  assign mapped    = sel_ctrl | sel_data | sel_width | sel_noise;

  // Only the two-bit code fields have an illegal encoding.
  assign bad_val = (sel_ctrl | sel_width) & (pwdata_i[1:0] == CODE_ILLEG);
  assign wr_err  = wr & (busy_i | ~mapped | bad_val);
  assign wr_ok   = wr & ~wr_err;

  assign pslverr_o   = wr_err | (rd & ~mapped);
  assign launch_o    = wr_ok & sel_ctrl;
  assign launch_op_o = op_t'(pwdata_i[1:0]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q    <= 2'd0;
      data_in_q <= '0;
      width_q   <= 2'd0;
      noise_q   <= '0;
    end else if (wr_ok) begin
      if (sel_ctrl)  ctrl_q    <= pwdata_i[1:0];
      if (sel_data)  data_in_q <= pwdata_i;
      if (sel_width) width_q   <= pwdata_i[1:0];
      if (sel_noise) noise_q   <= pwdata_i;
    end
  end

  always_comb begin
    prdata_o = '0;
    if (rd) begin
      if (sel_ctrl)  prdata_o = AMBA_WORD'(ctrl_q);
      if (sel_data)  prdata_o = data_in_q;
      if (sel_width) prdata_o = AMBA_WORD'(width_q);
      if (sel_noise) prdata_o = noise_q;
    end
  end

  assign data_in_o = data_in_q;
  assign width_o   = width_q;
  assign noise_o   = noise_q;

endmodule

// File: rtl/ecc_op_sequencer.sv
// ECC operation sequencer: APB-configured FSM that drives the encoder/decoder
// cores, guards each wait with a watchdog and publishes the result.
module ecc_op_sequencer
  import ecc_pkg::*;
#(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH      = 32,
  parameter int TIMEOUT_CYC     = 64
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  output logic                       enc_start,
  output logic [DATA_WIDTH-1:0]      enc_data,
  output logic [1:0]                 enc_width,
  input  logic                       enc_valid,
  input  logic [DATA_WIDTH-1:0]      enc_codeword,
  output logic                       dec_start,
  output logic [DATA_WIDTH-1:0]      dec_data,
  output logic [1:0]                 dec_width,
  input  logic                       dec_valid,
  input  logic [DATA_WIDTH-1:0]      dec_result,
  input  logic [1:0]                 dec_errors,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [1:0]                 num_of_errors,
  output logic                       operation_done,
  output logic                       busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic                 launch;
  op_t                  launch_op;
  logic [AMBA_WORD-1:0] data_in;
  logic [1:0]           width_code;
  logic [AMBA_WORD-1:0] noise;

  state_t                state_q, state_d;
  op_t                   op_q, op_d;
  logic [1:0]            wcode_q, wcode_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dec_data_q, dec_data_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [1:0]            nerr_q, nerr_d;

  logic [DATA_WIDTH-1:0] mask, enc_cw, dec_res, noise_m;
  logic                  timeout;

  ecc_apb_regs #(
    .AMBA_WORD       (AMBA_WORD),
    .AMBA_ADDR_WIDTH (AMBA_ADDR_WIDTH)
  ) u_regs (
    .clk_i       (PCLK),
    .rst_ni      (PRESETn),
    .psel_i      (PSEL),
    .penable_i   (PENABLE),
    .pwrite_i    (PWRITE),
    .paddr_i     (PADDR),
    .pwdata_i    (PWDATA),
    .prdata_o    (PRDATA),
    .pslverr_o   (PSLVERR),
    .busy_i      (busy),
    .launch_o    (launch),
    .launch_op_o (launch_op),
    .data_in_o   (data_in),
    .width_o     (width_code),
    .noise_o     (noise)
  );

  assign PREADY = 1'b1;

  // Width is frozen at launch, so every mask below uses the latched code.
  assign mask    = DATA_WIDTH'(width_mask(wcode_q));
  assign enc_cw  = enc_codeword & mask;
  assign dec_res = dec_result & mask;
  assign noise_m = DATA_WIDTH'(noise) & mask;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= S_IDLE;
      op_q       <= OP_ENC;
      wcode_q    <= 2'd0;
      cnt_q      <= '0;
      dec_data_q <= '0;
      data_out_q <= '0;
      nerr_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wcode_q    <= wcode_d;
      cnt_q      <= cnt_d;
      dec_data_q <= dec_data_d;
      data_out_q <= data_out_d;
      nerr_q     <= nerr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wcode_d    = wcode_q;
    cnt_d      = cnt_q;
    dec_data_d = dec_data_q;
    data_out_d = data_out_q;
    nerr_d     = nerr_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (launch) begin
          op_d    = launch_op;
          wcode_d = width_code;
          if (launch_op == OP_DEC) begin
            dec_data_d = DATA_WIDTH'(data_in);
            state_d    = S_DEC_START;
          end else begin
            state_d = S_ENC_START;
          end
        end
      end
      S_ENC_START: begin
        cnt_d   = '0;
        state_d = S_ENC_WAIT;
      end
      S_ENC_WAIT: begin
        if (enc_valid) begin
          if (op_q == OP_FULL) begin
            dec_data_d = enc_cw ^ noise_m;
            state_d    = S_DEC_START;
          end else begin
            data_out_d = enc_cw;
            nerr_d     = 2'd0;
            state_d    = S_DONE;
          end
        end else if (timeout) begin
          data_out_d = '0;
          nerr_d     = ERR_TIMEOUT;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DEC_START: begin
        cnt_d   = '0;
        state_d = S_DEC_WAIT;
      end
      S_DEC_WAIT: begin
        if (dec_valid) begin
          data_out_d = dec_res;
          nerr_d     = dec_errors;
          state_d    = S_DONE;
        end else if (timeout) begin
          data_out_d = '0;
          nerr_d     = ERR_TIMEOUT;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    enc_start      = 1'b0;
    dec_start      = 1'b0;
    operation_done = 1'b0;
    busy           = (state_q != S_IDLE);
    case (state_q)
      S_ENC_START: enc_start      = 1'b1;
      S_DEC_START: dec_start      = 1'b1;
      S_DONE:      operation_done = 1'b1;
      default: ;
    endcase
  end

  assign enc_data      = DATA_WIDTH'(data_in);
  assign enc_width     = wcode_q;
  assign dec_width     = wcode_q;
  assign dec_data      = dec_data_q;
  assign data_out      = data_out_q;
  assign num_of_errors = nerr_q;

endmodule

// File: doc/ecc_op_sequencer.md
Name: ecc_op_sequencer

Overview:
- APB slave register file plus control FSM that configures and sequences the ECC encoder and decoder cores.
- A write to CTRL launches an operation: Encode, Decode, or Full Channel (encode, XOR NOISE, decode).
- Drives the core start pulses, watches for completion with a watchdog, and publishes data_out, num_of_errors and a one-cycle operation_done pulse to the top level.

Parameters:
AMBA_WORD, 32, APB data width
AMBA_ADDR_WIDTH, 20, APB address width
DATA_WIDTH, 32, max codeword/data width
TIMEOUT_CYC, 64, max cycles to wait for a core valid

Ports:
PCLK  in  1  single clock
PRESETn  in  1  asynchronous active-low reset
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  1=write
PADDR  in  AMBA_ADDR_WIDTH  byte address
PWDATA  in  AMBA_WORD  write data
PRDATA  out  AMBA_WORD  read data
PREADY  out  1  tied 1 (zero wait states)
PSLVERR  out  1  access error flag
enc_start  out  1  encoder start pulse
enc_data  out  DATA_WIDTH  encoder input (DATA_IN)
enc_width  out  2  codeword width code to encoder
enc_valid  in  1  encoder result valid
enc_codeword  in  DATA_WIDTH  encoder result
dec_start  out  1  decoder start pulse
dec_data  out  DATA_WIDTH  decoder input
dec_width  out  2  width code to decoder
dec_valid  in  1  decoder result valid
dec_result  in  DATA_WIDTH  corrected data
dec_errors  in  2  0/1/2 errors detected
data_out  out  DATA_WIDTH  operation result
num_of_errors  out  2  error count; 3 = timeout
operation_done  out  1  one-cycle completion pulse
busy  out  1  operation in progress

Behaviour:
- Reset (PRESETn low, async): all registers 0, FSM IDLE; PRDATA, PSLVERR, starts, data_out, num_of_errors, operation_done, busy all 0.
- Register map, word aligned:
  - 0x00 CTRL[1:0]: 0 Encode, 1 Decode, 2 Full Channel.
  - 0x04 DATA_IN[31:0].
  - 0x08 CODEWORD_WIDTH[1:0]: 0=8b, 1=16b, 2=32b.
  - 0x0C NOISE[31:0].
- Write commits on PSEL&PENABLE&PWRITE; PSLVERR is asserted in that same access cycle when the write is rejected.
- Reads:
  - Combinational PRDATA during PSEL&PENABLE&!PWRITE, zero-extended register value.
  - Allowed at any time, including while busy.
  - Unmapped address: PRDATA=0, PSLVERR=1.
- Rejected writes (register unchanged, PSLVERR=1):
  - any write while busy;
  - CTRL or CODEWORD_WIDTH value 3;
  - unmapped address.
- Launch: an accepted CTRL write in cycle T → busy=1 from T+1.
- FSM states: IDLE, ENC_START, ENC_WAIT, DEC_START, DEC_WAIT, DONE.
  - IDLE → ENC_START (CTRL 0 or 2) or DEC_START (CTRL 1) on accepted CTRL write.
  - ENC_START: enc_start=1 for exactly one cycle → ENC_WAIT.
  - ENC_WAIT, on enc_valid, capture enc_codeword:
    - Encode → DONE, data_out=codeword.
    - Full Channel → DEC_START with dec_data = codeword XOR (NOISE masked to width).
  - DEC_START: dec_start=1 one cycle; dec_data = DATA_IN for Decode → DEC_WAIT.
  - DEC_WAIT, on dec_valid: capture dec_result and dec_errors → DONE.
  - DONE: operation_done=1 for one cycle; busy=0 next cycle → IDLE.
- Timing:
  - A valid arriving in the first WAIT cycle gives operation_done at T+3 for Encode/Decode and T+5 for Full Channel.
  - Valid is sampled only in WAIT states; a valid during a START cycle is ignored.
- Width masking: width mask 0xFF/0xFFFF/0xFFFFFFFF is applied to NOISE and to captured results; enc_width and dec_width are held from CODEWORD_WIDTH at launch.
- Encode completion: num_of_errors=0.
- Watchdog: counter cleared on entering each WAIT state. If it reaches TIMEOUT_CYC without valid → DONE with num_of_errors=3 and data_out=0.
- data_out and num_of_errors hold until the next operation's DONE.
- Reset mid-operation: immediate return to IDLE; no operation_done pulse.

Decomposition:
- Package ecc_pkg:
  - op_t enum (OP_ENC, OP_DEC, OP_FULL);
  - state_t enum;
  - register address localparams;
  - width codes;
  - function width_mask(code).
- Sub-module ecc_apb_regs: APB decode, register storage, PSLVERR, accept/launch strobe.
- ecc_op_sequencer holds the FSM and watchdog.

Test Plan:
- Stub encoder with 2-cycle latency returning 0xA5 (8b). Write CODEWORD_WIDTH=0, DATA_IN=0x5, CTRL=0 → one enc_start pulse; operation_done at T+4; data_out=0xA5, num_of_errors=0.
- Full Channel, 16b. Stub encoder returns 0x1234, NOISE=0xFFFF0001 → dec_data=0x1235. Stub decoder returns 0x0234 with errors=1 → data_out=0x0234, num_of_errors=1.
- While busy: write DATA_IN=0xDEAD → PSLVERR=1, readback unchanged. Read CTRL while busy → PRDATA=0x2, PSLVERR=0.
- Write CTRL=3 or CODEWORD_WIDTH=3, and write to address 0x10 → PSLVERR=1, no launch, registers unchanged; read of 0x10 returns 0 with PSLVERR=1.
- Decoder never asserts valid, TIMEOUT_CYC=64 → operation_done 64 cycles after entering DEC_WAIT; num_of_errors=3, data_out=0.
- Assert PRESETn low during ENC_WAIT → busy=0 and all registers 0 immediately; no operation_done; a new CTRL write then completes normally.
